apb_master_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one apb_master instance between NUM_REQ local requesters. It latches the winning requester's command and drives the master's PMODE/PADDR/PWDATA/PSEL inputs. It holds the command until the master reports PREADY, then returns read data and error status to that requester. It sits directly in front of apb_master, with the master's PREADY_o, PRDATA_o and PSLVERR_o wired back into this block.

---
 rtl/apb_master_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_apb_master_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter/sequencer that shares one apb_master between NUM_REQ requesters.
// The winner's command is latched and driven to the master until PREADY_i, then
// read data and error status are returned to that requester with a one-cycle DONE_o.
// Optional build macro: APB_ARB_TIMEOUT_EN bounds the WAIT state to TIMEOUT_CYCLES.
module apb_master_arbiter #(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned PSEL_WIDTH     = 1,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                             PCLK_i,
    input  logic                             PRESET_i,
    input  logic [NUM_REQ-1:0]               REQ_i,
    input  logic [NUM_REQ-1:0]               REQ_WRITE_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    REQ_ADDR_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    REQ_WDATA_i,
    input  logic [NUM_REQ*PSEL_WIDTH-1:0]    REQ_PSEL_i,
    output logic [NUM_REQ-1:0]               GNT_o,
    output logic [NUM_REQ-1:0]               DONE_o,
    output logic [DATA_WIDTH-1:0]            RDATA_o,
    output logic                             SLVERR_o,
    output logic [1:0]                       PMODE_o,
    output logic [ADDR_WIDTH-1:0]            PADDR_o,
    output logic [DATA_WIDTH-1:0]            PWDATA_o,
    output logic [PSEL_WIDTH-1:0]            PSEL_o,
    input  logic                             PREADY_i,
    input  logic [DATA_WIDTH-1:0]            PRDATA_i,
    input  logic                             PSLVERR_i
);

    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {StIdle, StWait, StDone, StRelease} state_e;

    state_e state_q, state_d;

    logic [NUM_REQ-1:0]    gnt_q, gnt_d;
    logic [NUM_REQ-1:0]    done_q, done_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  slverr_q, slverr_d;
    logic [1:0]            pmode_q, pmode_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [PSEL_WIDTH-1:0] psel_q, psel_d;
    logic [IdxW-1:0]       last_q, last_d;

    logic [IdxW-1:0]       win_idx;
    logic                  win_found;
    logic                  timed_out;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] tmo_q, tmo_d;

    // WAIT-cycle counter: cleared on entry to WAIT, counts every WAIT cycle.
    always_comb begin
        tmo_d = tmo_q;
        if (state_q == StIdle) begin
            tmo_d = '0;
        end else if (state_q == StWait) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    // Timeout counter register.
    always_ff @(posedge PCLK_i) begin
        if (!PRESET_i) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end

    // Fires on the edge that ends the TIMEOUT_CYCLES-th WAIT cycle.
    assign timed_out = (tmo_q == CntW'(TIMEOUT_CYCLES - 1));
`else
    assign timed_out = 1'b0;
`endif

    // Round-robin search starting one past the last winner, wrapping modulo NUM_REQ.
    always_comb begin : arbitrate
        int unsigned     cand;
        logic [IdxW-1:0] cand_idx;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand     = (32'(last_q) + i) % NUM_REQ;
            cand_idx = IdxW'(cand);
            if (!win_found && REQ_i[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    // State register.
    always_ff @(posedge PCLK_i) begin
        if (!PRESET_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (win_found) state_d = StWait;
            StWait:    if (PREADY_i || timed_out) state_d = StDone;
            StDone:    state_d = StRelease;
            StRelease: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Next values of the registered outputs and the round-robin pointer.
    always_comb begin
        gnt_d    = gnt_q;
        done_d   = '0;
        rdata_d  = rdata_q;
        slverr_d = slverr_q;
        pmode_d  = pmode_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        psel_d   = psel_q;
        last_d   = last_q;
        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    gnt_d          = '0;
                    gnt_d[win_idx] = 1'b1;
                    pmode_d        = {1'b1, REQ_WRITE_i[win_idx]};
                    paddr_d        = REQ_ADDR_i[32'(win_idx) * ADDR_WIDTH +: ADDR_WIDTH];
                    pwdata_d       = REQ_WDATA_i[32'(win_idx) * DATA_WIDTH +: DATA_WIDTH];
                    psel_d         = REQ_PSEL_i[32'(win_idx) * PSEL_WIDTH +: PSEL_WIDTH];
                    last_d         = win_idx;
                end
            end
            StWait: begin
                // A real PREADY takes priority over a coincident timeout.
                if (PREADY_i) begin
                    rdata_d  = pmode_q[0] ? '0 : PRDATA_i;
                    slverr_d = PSLVERR_i;
                    pmode_d  = 2'b00;
                    done_d   = gnt_q;
                end else if (timed_out) begin
                    rdata_d  = '0;
                    slverr_d = 1'b1;
                    pmode_d  = 2'b00;
                    done_d   = gnt_q;
                end
            end
            StDone: begin
                gnt_d    = '0;
                rdata_d  = '0;
                slverr_d = 1'b0;
            end
            StRelease: begin
                pmode_d = 2'b00;
            end
            default: begin
                pmode_d = 2'b00;
            end
        endcase
    end

    // Output and pointer registers; reset abandons any transfer without a DONE.
    always_ff @(posedge PCLK_i) begin
        if (!PRESET_i) begin
            gnt_q    <= '0;
            done_q   <= '0;
            rdata_q  <= '0;
            slverr_q <= 1'b0;
            pmode_q  <= 2'b00;
            paddr_q  <= '0;
            pwdata_q <= '0;
            psel_q   <= '0;
            last_q   <= IdxW'(NUM_REQ - 1);
        end else begin
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            rdata_q  <= rdata_d;
            slverr_q <= slverr_d;
            pmode_q  <= pmode_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            psel_q   <= psel_d;
            last_q   <= last_d;
        end
    end

    assign GNT_o    = gnt_q;
    assign DONE_o   = done_q;
    assign RDATA_o  = rdata_q;
    assign SLVERR_o = slverr_q;
    assign PMODE_o  = pmode_q;
    assign PADDR_o  = paddr_q;
    assign PWDATA_o = pwdata_q;
    assign PSEL_o   = psel_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Self-checking bench for apb_master_arbiter: a behavioural slave answers on the
// master-side ports, and expected completions are queued when requests are raised.
module tb_apb_master_arbiter;

    localparam int unsigned NReq = 2;

    logic        pclk;
    logic        preset;
    logic [1:0]  req;
    logic [1:0]  req_write;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  req_psel;
    logic [1:0]  gnt;
    logic [1:0]  done;
    logic [7:0]  rdata;
    logic        slverr;
    logic [1:0]  pmode;
    logic [7:0]  paddr;
    logic [7:0]  pwdata;
    logic [0:0]  psel;
    logic        pready;
    logic [7:0]  prdata;
    logic        pslverr;

    apb_master_arbiter #(
        .NUM_REQ        (NReq),
        .ADDR_WIDTH     (8),
        .DATA_WIDTH     (8),
        .PSEL_WIDTH     (1),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .PCLK_i      (pclk),
        .PRESET_i    (preset),
        .REQ_i       (req),
        .REQ_WRITE_i (req_write),
        .REQ_ADDR_i  (req_addr),
        .REQ_WDATA_i (req_wdata),
        .REQ_PSEL_i  (req_psel),
        .GNT_o       (gnt),
        .DONE_o      (done),
        .RDATA_o     (rdata),
        .SLVERR_o    (slverr),
        .PMODE_o     (pmode),
        .PADDR_o     (paddr),
        .PWDATA_o    (pwdata),
        .PSEL_o      (psel),
        .PREADY_i    (pready),
        .PRDATA_i    (prdata),
        .PSLVERR_i   (pslverr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    typedef struct packed {
        logic [1:0] gnt;
        logic [1:0] pmode;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        logic       err;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Slave behaviour: answers slv_delay cycles into a transfer; read data = addr ^ 0x3D.
    int slv_delay = 0;
    bit slv_err   = 1'b0;
    int wcnt      = 0;

    always @(negedge pclk) begin
        if (pmode == 2'b00) begin
            pready  = 1'b0;
            prdata  = 8'hEE;
            pslverr = 1'b1;
            wcnt    = 0;
        end else if (pready) begin
            pready = 1'b0;
        end else if (wcnt >= slv_delay) begin
            pready  = 1'b1;
            prdata  = paddr ^ 8'h3D;
            pslverr = slv_err;
        end else begin
            wcnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int k, input bit wr, input logic [7:0] a, input logic [7:0] wd);
        req_write[k]       = wr;
        req_addr[k*8 +: 8]  = a;
        req_wdata[k*8 +: 8] = wd;
        req_psel[k]        = 1'b1;
    endtask

    task automatic push_exp(input int k, input bit wr, input logic [7:0] a,
                            input logic [7:0] wd, input bit err);
        exp_t e;
        e.gnt   = 2'(1 << k);
        e.pmode = {1'b1, wr};
        e.addr  = a;
        e.wdata = wd;
        e.rdata = wr ? 8'h00 : (a ^ 8'h3D);
        e.err   = err;
        sb.push_back(e);
    endtask

    task automatic all_zero(input string tag);
        chk(tag, {gnt, done, rdata, slverr, pmode, paddr, pwdata, psel}, 32'h0);
    endtask

    task automatic do_reset();
        preset = 1'b0;
        req    = 2'b00;
        repeat (2) @(negedge pclk);
        all_zero("reset_outputs");
        preset = 1'b1;
    endtask

    // Watch one transfer to completion, checking the master-side command every WAIT
    // cycle and the returned status at DONE, then the clear on the following cycle.
    task automatic wait_done(input int budget, output int nwait);
        exp_t e;
        bit   got;
        got   = 1'b0;
        nwait = 0;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = sb[0];
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge pclk);
            if (done != 2'b00) begin
                void'(sb.pop_front());
                chk("done_vec", 32'(done), 32'(e.gnt));
                chk("done_gnt", 32'(gnt), 32'(e.gnt));
                chk("done_rdata", 32'(rdata), 32'(e.rdata));
                chk("done_slverr", 32'(slverr), 32'(e.err));
                chk("done_pmode", 32'(pmode), 32'd0);
                got = 1'b1;
            end else if (pmode != 2'b00) begin
                nwait++;
                chk("wait_pmode", 32'(pmode), 32'(e.pmode));
                chk("wait_paddr", 32'(paddr), 32'(e.addr));
                chk("wait_gnt", 32'(gnt), 32'(e.gnt));
                if (e.pmode[0]) chk("wait_pwdata", 32'(pwdata), 32'(e.wdata));
            end
        end
        if (!got) begin
            chk("done_timeout", 32'd0, 32'd1);
        end else begin
            @(negedge pclk);
            chk("clr_done", 32'(done), 32'd0);
            chk("clr_gnt", 32'(gnt), 32'd0);
            chk("clr_rdata", 32'(rdata), 32'd0);
            chk("clr_slverr", 32'(slverr), 32'd0);
            chk("clr_pmode", 32'(pmode), 32'd0);
        end
    endtask

    initial begin : main
        int nw;
        int nd;
        preset    = 1'b0;
        req       = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_psel  = '0;

        // 1: single read from requester 0
        do_reset();
        @(negedge pclk);
        set_req(0, 1'b0, 8'h15, 8'h00);
        push_exp(0, 1'b0, 8'h15, 8'h00, 1'b0);
        req = 2'b01;
        @(negedge pclk);
        chk("t1_issue_pmode", 32'(pmode), 32'h2);
        chk("t1_issue_gnt", 32'(gnt), 32'h1);
        wait_done(20, nw);
        req[0] = 1'b0;

        // 2: both held, grants alternate starting at requester 0
        do_reset();
        set_req(0, 1'b1, 8'h01, 8'h72);
        set_req(1, 1'b0, 8'h02, 8'h00);
        for (int i = 0; i < 2; i++) begin
            push_exp(0, 1'b1, 8'h01, 8'h72, 1'b0);
            push_exp(1, 1'b0, 8'h02, 8'h00, 1'b0);
        end
        req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            wait_done(20, nw);
            if (i == 3) req = 2'b00;
            @(negedge pclk);
            chk("t2_release_idle", 32'(pmode), 32'd0);
        end

        // 3: delayed PREADY, requester inputs change during WAIT
        slv_delay = 3;
        set_req(0, 1'b0, 8'h44, 8'h00);
        push_exp(0, 1'b0, 8'h44, 8'h00, 1'b0);
        req = 2'b01;
        @(negedge pclk);
        req_addr[7:0] = 8'h99;
        req_write[0]  = 1'b1;
        wait_done(20, nw);
        chk("t3_wait_cycles", 32'(nw), 32'd3);
        req[0]    = 1'b0;
        slv_delay = 0;

        // 4: slave error reported with the completion
        slv_err = 1'b1;
        set_req(1, 1'b0, 8'h30, 8'h00);
        push_exp(1, 1'b0, 8'h30, 8'h00, 1'b1);
        req = 2'b10;
        wait_done(20, nw);
        req[1]  = 1'b0;
        slv_err = 1'b0;

        // 5: reset during WAIT abandons the transfer and restores priority to requester 0
        repeat (2) @(negedge pclk);
        slv_delay = 20;
        set_req(0, 1'b0, 8'h50, 8'h00);
        req = 2'b01;
        repeat (3) @(negedge pclk);
        chk("t5_in_wait", 32'(pmode), 32'h2);
        preset = 1'b0;
        req    = 2'b00;
        @(negedge pclk);
        all_zero("t5_reset_outputs");
        preset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            chk("t5_no_done", 32'(done), 32'd0);
        end
        slv_delay = 0;
        set_req(0, 1'b0, 8'h62, 8'h00);
        set_req(1, 1'b0, 8'h61, 8'h00);
        push_exp(0, 1'b0, 8'h62, 8'h00, 1'b0);
        push_exp(1, 1'b0, 8'h61, 8'h00, 1'b0);
        req = 2'b11;
        @(negedge pclk);
        chk("t5_first_gnt", 32'(gnt), 32'h1);
        wait_done(20, nw);
        req[0] = 1'b0;
        wait_done(20, nw);
        req[1] = 1'b0;

        // 6: slave never answers
        repeat (2) @(negedge pclk);
        slv_delay = 1000;
        set_req(0, 1'b0, 8'h77, 8'h00);
`ifdef APB_ARB_TIMEOUT_EN
        begin
            exp_t e;
            e.gnt   = 2'b01;
            e.pmode = 2'b10;
            e.addr  = 8'h77;
            e.wdata = 8'h00;
            e.rdata = 8'h00;
            e.err   = 1'b1;
            sb.push_back(e);
        end
        req = 2'b01;
        wait_done(20, nw);
        chk("t6_wait_cycles", 32'(nw), 32'd4);
        req = 2'b00;
`else
        req = 2'b01;
        nd  = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge pclk);
            if (done != 2'b00) nd++;
        end
        chk("t6_no_done", 32'(nd), 32'd0);
        chk("t6_still_waiting", 32'(pmode), 32'h2);
        do_reset();
`endif
        slv_delay = 0;
        repeat (3) @(negedge pclk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
